// File: rtl/grad_bin_cal.sv
// grad_bin_cal: per-lane image gradient magnitude and 9-way orientation bin.
// Three-stage valid/ready pipeline: S1 abs/sign, S2 products, S3 compare/sum.
// Optional macro GRAD_MAG_L2_EN selects mag = gx^2 + gy^2 instead of |gx| + |gy|.
module grad_bin_cal #(
   parameter int PIX_W = 8,
   parameter int LANES = 2,
   localparam int MAG_W = 2*PIX_W+1,
   localparam int BIN_W = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [LANES*4*PIX_W-1:0] pixel,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [LANES*MAG_W-1:0]   mag,
   output logic [LANES*BIN_W-1:0]   bin
);

   localparam int GY_W = PIX_W+12;
   localparam int GX_W = PIX_W+15;
   localparam logic [14:0] THR [4] = '{15'd1491, 15'd3437, 15'd7094, 15'd23230};

   logic v1, v2, v3;
   logic en1, en2, en3, accept;

   logic signed [PIX_W:0] gx_c [LANES];
   logic signed [PIX_W:0] gy_c [LANES];
   logic [PIX_W-1:0]      ax_c [LANES];
   logic [PIX_W-1:0]      ay_c [LANES];
   logic                  opp_c [LANES];
   logic                  zz_c [LANES];

   logic [PIX_W-1:0] ax1 [LANES];
   logic [PIX_W-1:0] ay1 [LANES];
   logic             opp1 [LANES];
   logic             zz1 [LANES];

   logic [GY_W-1:0]  py2 [LANES];
   logic [GX_W-1:0]  px2 [LANES][4];
   logic [MAG_W-1:0] ma2 [LANES];
   logic [MAG_W-1:0] mb2 [LANES];
   logic             opp2 [LANES];
   logic             zz2 [LANES];

   logic [2:0]               k_c;
   logic [LANES*MAG_W-1:0]   mag_c;
   logic [LANES*BIN_W-1:0]   bin_c;

   // A stage may load when it is empty or its contents move on this cycle
   assign en3      = !v3 || out_ready;
   assign en2      = !v2 || en3;
   assign en1      = !v1 || en2;
   assign in_ready = rst && en1;
   assign accept   = in_valid && in_ready;
   assign out_valid = v3;

   // Signed gradients, their magnitudes and sign relations for every lane
   always_comb begin
      for (int i = 0; i < LANES; i++) begin
         gx_c[i]  = $signed({1'b0, pixel[i*4*PIX_W +: PIX_W]})
                  - $signed({1'b0, pixel[i*4*PIX_W+PIX_W +: PIX_W]});
         gy_c[i]  = $signed({1'b0, pixel[i*4*PIX_W+2*PIX_W +: PIX_W]})
                  - $signed({1'b0, pixel[i*4*PIX_W+3*PIX_W +: PIX_W]});
         ax_c[i]  = PIX_W'(gx_c[i][PIX_W] ? -gx_c[i] : gx_c[i]);
         ay_c[i]  = PIX_W'(gy_c[i][PIX_W] ? -gy_c[i] : gy_c[i]);
         zz_c[i]  = (gx_c[i] == '0) && (gy_c[i] == '0);
         opp_c[i] = (gx_c[i][PIX_W] != gy_c[i][PIX_W]) && (gx_c[i] != '0) && (gy_c[i] != '0);
      end
   end

   // S1: capture abs values and sign relation of the accepted beat
   always_ff @(posedge clk) begin
      if (en1 && accept) begin
         for (int i = 0; i < LANES; i++) begin
            ax1[i]  <= ax_c[i];
            ay1[i]  <= ay_c[i];
            opp1[i] <= opp_c[i];
            zz1[i]  <= zz_c[i];
         end
      end
   end

   // S2: scaled |gy|, |gx| times each tangent threshold, and magnitude terms
   always_ff @(posedge clk) begin
      if (en2 && v1) begin
         for (int i = 0; i < LANES; i++) begin
            py2[i] <= {ay1[i], 12'b0};
            for (int j = 0; j < 4; j++) begin
               px2[i][j] <= GX_W'(ax1[i]) * GX_W'(THR[j]);
            end
`ifdef GRAD_MAG_L2_EN
            ma2[i] <= MAG_W'(ax1[i]) * MAG_W'(ax1[i]);
            mb2[i] <= MAG_W'(ay1[i]) * MAG_W'(ay1[i]);
`else
            ma2[i] <= MAG_W'(ax1[i]);
            mb2[i] <= MAG_W'(ay1[i]);
`endif
            opp2[i] <= opp1[i];
            zz2[i]  <= zz1[i];
         end
      end
   end

   // S3 combinational: count thresholds passed, fold by quadrant, sum magnitude
   always_comb begin
      mag_c = '0;
      bin_c = '0;
      k_c   = '0;
      for (int i = 0; i < LANES; i++) begin
         k_c = '0;
         for (int j = 0; j < 4; j++) begin
            if (GX_W'(py2[i]) >= px2[i][j]) begin
               k_c = k_c + 3'd1;
            end
         end
         if (zz2[i]) begin
            bin_c[i*BIN_W +: BIN_W] = '0;
         end else if (opp2[i]) begin
            bin_c[i*BIN_W +: BIN_W] = 4'd8 - {1'b0, k_c};
         end else begin
            bin_c[i*BIN_W +: BIN_W] = {1'b0, k_c};
         end
         mag_c[i*MAG_W +: MAG_W] = ma2[i] + mb2[i];
      end
   end

   // Stage valid flags and the output register, all cleared by reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         v1  <= 1'b0;
         v2  <= 1'b0;
         v3  <= 1'b0;
         mag <= '0;
         bin <= '0;
      end else begin
         if (en1) v1 <= accept;
         if (en2) v2 <= v1;
         if (en3) begin
            v3 <= v2;
            if (v2) begin
               mag <= mag_c;
               bin <= bin_c;
            end
         end
      end
   end

endmodule

// File: tb/tb_grad_bin_cal.sv
// tb_grad_bin_cal: directed and randomized checks of grad_bin_cal against a
// behavioural model; honours GRAD_MAG_L2_EN for the expected magnitude.
module tb_grad_bin_cal;

   localparam int PW = 8;
   localparam int MW = 2*PW+1;
   localparam int LN = 2;

   logic clk = 1'b0;
   logic rst;
   logic in_valid, in_ready, out_valid, out_ready;
   logic [LN*4*PW-1:0] pixel;
   logic [LN*MW-1:0]   mag;
   logic [LN*4-1:0]    bin;

   logic in_valid1, in_ready1, out_valid1;
   logic [4*PW-1:0] pixel1;
   logic [MW-1:0]   mag1;
   logic [3:0]      bin1;

   logic in_valid4, in_ready4, out_valid4;
   logic [4*4*PW-1:0] pixel4;
   logic [4*MW-1:0]   mag4;
   logic [15:0]       bin4;

   logic one = 1'b1;

   int checks = 0;
   int errors = 0;

   typedef logic [LN*MW+LN*4-1:0] entry_t;
   entry_t q[$];

   grad_bin_cal #(.PIX_W(PW), .LANES(LN)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .pixel(pixel),
      .out_valid(out_valid), .out_ready(out_ready), .mag(mag), .bin(bin));

   grad_bin_cal #(.PIX_W(PW), .LANES(1)) u1 (
      .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .pixel(pixel1),
      .out_valid(out_valid1), .out_ready(one), .mag(mag1), .bin(bin1));

   grad_bin_cal #(.PIX_W(PW), .LANES(4)) u4 (
      .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4), .pixel(pixel4),
      .out_valid(out_valid4), .out_ready(one), .mag(mag4), .bin(bin4));

   // Free-running clock
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic [4*PW-1:0] lane(input int t, input int b, input int l, input int r);
      return {PW'(t), PW'(b), PW'(l), PW'(r)};
   endfunction

   // Orientation bin from the tangent thresholds, magnitude by L1 or L2 norm
   function automatic void lane_model(input logic [4*PW-1:0] p, output int m, output int b);
      int thr[4] = '{1491, 3437, 7094, 23230};
      int gx, gy, ax, ay, k;
      gx = int'(p[0 +: PW]) - int'(p[PW +: PW]);
      gy = int'(p[2*PW +: PW]) - int'(p[3*PW +: PW]);
      ax = (gx < 0) ? -gx : gx;
      ay = (gy < 0) ? -gy : gy;
      k = 0;
      foreach (thr[j]) if (ay*4096 >= ax*thr[j]) k++;
      if (gx == 0 && gy == 0) b = 0;
      else if ((gx < 0 && gy > 0) || (gx > 0 && gy < 0)) b = 8 - k;
      else b = k;
`ifdef GRAD_MAG_L2_EN
      m = gx*gx + gy*gy;
`else
      m = ax + ay;
`endif
   endfunction

   function automatic entry_t vec_model(input logic [LN*4*PW-1:0] p);
      logic [LN*MW-1:0] mv;
      logic [LN*4-1:0]  bv;
      int m, b;
      for (int l = 0; l < LN; l++) begin
         lane_model(p[l*4*PW +: 4*PW], m, b);
         mv[l*MW +: MW] = MW'(m);
         bv[l*4 +: 4]   = 4'(b);
      end
      return {mv, bv};
   endfunction

   task automatic applyStimulus(input logic [LN*4*PW-1:0] p, input logic [LN*MW-1:0] em,
                                input logic [LN*4-1:0] eb, input string tag);
      int n;
      in_valid = 1'b1;
      pixel = p;
      @(negedge clk);
      checkOutput({tag, "_in_ready"}, 128'(in_ready), 128'(1));
      @(posedge clk); #1;
      in_valid = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!out_valid && n < 10);
      checkOutput({tag, "_latency"}, 128'(n), 128'(3));
      checkOutput({tag, "_mag"}, 128'(mag), 128'(em));
      checkOutput({tag, "_bin"}, 128'(bin), 128'(eb));
      @(posedge clk); #1;
   endtask

   initial begin
      int n, m, b, cyc, accepted, produced;
      logic held;
      logic [LN*MW-1:0] hold_mag;
      logic [LN*4-1:0]  hold_bin;
      entry_t e;

      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; pixel = '0;
      in_valid1 = 1'b0; pixel1 = '0; in_valid4 = 1'b0; pixel4 = '0;
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      checkOutput("reset_in_ready", 128'(in_ready), 128'(0));
      checkOutput("reset_out_valid", 128'(out_valid), 128'(0));
      checkOutput("reset_mag", 128'(mag), 128'(0));
      checkOutput("reset_bin", 128'(bin), 128'(0));
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      checkOutput("release_in_ready", 128'(in_ready), 128'(1));
      @(posedge clk); #1;

`ifdef GRAD_MAG_L2_EN
      applyStimulus({lane(0,10,0,30), lane(10,50,20,20)}, {MW'(1000), MW'(1600)}, 8'h04, "vert_horiz");
      applyStimulus({lane(255,255,255,255), lane(10,0,20,30)}, {MW'(0), MW'(200)}, 8'h06, "opp45_flat");
      applyStimulus({lane(0,4,0,10), lane(255,0,0,255)}, {MW'(116), MW'(130050)}, 8'h16, "max_edge");
`else
      applyStimulus({lane(0,10,0,30), lane(10,50,20,20)}, {MW'(40), MW'(40)}, 8'h04, "vert_horiz");
      applyStimulus({lane(255,255,255,255), lane(10,0,20,30)}, {MW'(0), MW'(20)}, 8'h06, "opp45_flat");
      applyStimulus({lane(0,4,0,10), lane(255,0,0,255)}, {MW'(14), MW'(510)}, 8'h16, "max_edge");
`endif

      // 100 random beats, out_ready toggling randomly
      accepted = 0; produced = 0; cyc = 0; held = 1'b0;
      hold_mag = '0; hold_bin = '0;
      in_valid = 1'b1;
      pixel = {$urandom, $urandom};
      out_ready = 1'($urandom_range(0, 1));
      while ((accepted < 100 || q.size() > 0) && cyc < 3000) begin
         @(negedge clk);
         if (held) begin
            checkOutput("stall_valid", 128'(out_valid), 128'(1));
            checkOutput("stall_mag", 128'(mag), 128'(hold_mag));
            checkOutput("stall_bin", 128'(bin), 128'(hold_bin));
         end
         held = out_valid && !out_ready;
         hold_mag = mag;
         hold_bin = bin;
         n = 0;
         if (in_valid && in_ready) begin
            q.push_back(vec_model(pixel));
            accepted++;
            n = 1;
         end
         if (out_valid && out_ready) begin
            produced++;
            if (q.size() > 0) begin
               e = q.pop_front();
               checkOutput("rand_mag", 128'(mag), 128'(e[LN*4 +: LN*MW]));
               checkOutput("rand_bin", 128'(bin), 128'(e[LN*4-1:0]));
            end
         end
         @(posedge clk); #1;
         cyc++;
         if (n == 1) pixel = {$urandom, $urandom};
         in_valid = (accepted < 100);
         out_ready = 1'($urandom_range(0, 1));
      end
      checkOutput("rand_no_timeout", 128'(cyc < 3000), 128'(1));
      checkOutput("rand_out_count", 128'(produced), 128'(100));
      in_valid = 1'b0;
      out_ready = 1'b1;
      repeat (5) @(posedge clk);
      #1;

      // Fill the pipe with 3 stalled beats, then reset mid-flight
      out_ready = 1'b0;
      in_valid = 1'b1;
      pixel = {$urandom, $urandom};
      n = 0; cyc = 0;
      while (n < 3 && cyc < 20) begin
         @(negedge clk);
         if (in_valid && in_ready) n++;
         @(posedge clk); #1;
         pixel = {$urandom, $urandom};
         cyc++;
      end
      in_valid = 1'b0;
      @(negedge clk);
      checkOutput("flight_out_valid", 128'(out_valid), 128'(1));
      checkOutput("flight_full_in_ready", 128'(in_ready), 128'(0));
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      checkOutput("midrst_in_ready", 128'(in_ready), 128'(0));
      @(posedge clk); #1;
      @(negedge clk);
      checkOutput("midrst_out_valid", 128'(out_valid), 128'(0));
      checkOutput("midrst_mag", 128'(mag), 128'(0));
      checkOutput("midrst_in_ready2", 128'(in_ready), 128'(0));
      @(posedge clk); #1;
      rst = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      checkOutput("midrst_release_in_ready", 128'(in_ready), 128'(1));
      n = 0;
      repeat (10) begin
         @(negedge clk);
         if (out_valid) n++;
         @(posedge clk); #1;
      end
      checkOutput("midrst_no_stale", 128'(n), 128'(0));

      // LANES=1 and LANES=4 builds around the first-bin boundary
      pixel1 = lane(0,4,0,10);
      pixel4 = {lane(0,10,0,4), lane(0,4,10,0), lane(0,3,0,10), lane(0,4,0,10)};
      in_valid1 = 1'b1;
      in_valid4 = 1'b1;
      @(negedge clk);
      checkOutput("u4_in_ready", 128'(in_ready4), 128'(1));
      checkOutput("u1_in_ready", 128'(in_ready1), 128'(1));
      @(posedge clk); #1;
      in_valid1 = 1'b0;
      in_valid4 = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!out_valid4 && n < 10);
      checkOutput("u4_latency", 128'(n), 128'(3));
      checkOutput("u1_valid", 128'(out_valid1), 128'(1));
      checkOutput("u4_bin", 128'(bin4), 128'(16'h3701));
      checkOutput("u1_bin", 128'(bin1), 128'(1));
      for (int l = 0; l < 4; l++) begin
         lane_model(pixel4[l*4*PW +: 4*PW], m, b);
         checkOutput("u4_mag", 128'(mag4[l*MW +: MW]), 128'(m));
      end
      lane_model(pixel1, m, b);
      checkOutput("u1_mag", 128'(mag1), 128'(m));
      @(posedge clk); #1;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
